// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the instruction decoder:
// sequencer states, opcode field geometry and the HALT opcode.
package fetch_sequencer_pkg;

  // Opcode occupies the top OP_W bits of an instruction word.
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] HALT_OP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_ACK,
    S_DONE,
    S_HALTED
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the sequencer's memory, cpu handshake and control signals.
// master = sequencer side, slave = memory/cpu/control side.
interface fetch_sequencer_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 8
);
  logic                run;
  logic                mem_rd;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_rdata;
  logic [WIDTH-1:0]    instr_out;
  logic                load_instr;
  logic                s;
  logic                w;
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_target;
  logic [PC_WIDTH-1:0] pc;
  logic                halted;

  modport master (
    input  run, mem_rdata, w, pc_load, pc_target,
    output mem_rd, mem_addr, instr_out, load_instr, s, pc, halted
  );

  modport slave (
    output run, mem_rdata, w, pc_load, pc_target,
    input  mem_rd, mem_addr, instr_out, load_instr, s, pc, halted
  );
endinterface

// File: rtl/fetch_sequencer_vdffe.sv
// Enable flop (vDFFE) with asynchronous active-low clear; holds the program counter.
module fetch_sequencer_vdffe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the pc, fetches one word per step from a
// synchronous-read memory, hands it to the cpu and waits for the w handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter int              PC_WIDTH = 8,
  parameter logic [OP_W-1:0] HALT_OP  = fetch_sequencer_pkg::HALT_OP
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
);

  state_t              r_state;
  state_t              w_next_state;
  logic [OP_W-1:0]     w_opcode;
  logic                w_is_halt;
  logic                w_redirect;
  logic                w_pc_en;
  logic [PC_WIDTH-1:0] w_pc_d;
  logic [PC_WIDTH-1:0] w_pc;

  assign w_opcode   = bus.mem_rdata[WIDTH-1 -: OP_W];
  assign w_is_halt  = (w_opcode == HALT_OP);
  assign w_redirect = (r_state == S_DONE) && bus.w && bus.pc_load;

  // Increment after a non-halt LOAD; a DONE redirect overrides that increment.
  assign w_pc_en = ((r_state == S_LOAD) && !w_is_halt) || w_redirect;
  assign w_pc_d  = (r_state == S_DONE) ? bus.pc_target : w_pc + PC_WIDTH'(1);

  fetch_sequencer_vdffe #(.N(PC_WIDTH)) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  // NOTE: state is sequential, so it is updated with <= only; the comb blocks use =.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.run) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_LOAD;
      S_LOAD:   w_next_state = w_is_halt ? S_HALTED : S_START;
      S_START:  w_next_state = S_ACK;
      S_ACK:    if (!bus.w) w_next_state = S_DONE;
      S_DONE:   if (bus.w) w_next_state = bus.run ? S_FETCH : S_IDLE;
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.instr_out  = '0;
    bus.load_instr = 1'b0;
    bus.s          = 1'b0;
    bus.halted     = 1'b0;
    case (r_state)
      S_FETCH:  bus.mem_rd = 1'b1;
      S_LOAD: begin
        bus.instr_out  = bus.mem_rdata;
        bus.load_instr = !w_is_halt;
      end
      S_START:  bus.s = 1'b1;
      S_HALTED: bus.halted = 1'b1;
      default:  ;
    endcase
  end

  assign bus.mem_addr = w_pc;
  assign bus.pc       = w_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer: synchronous-read memory model,
// cpu w handshake driven cycle by cycle, outputs sampled on the falling edge.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [15:0] mem [256];

  fetch_sequencer_if #(.WIDTH(16), .PC_WIDTH(8)) bus ();

  fetch_sequencer #(.WIDTH(16), .PC_WIDTH(8), .HALT_OP(3'b111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered on the falling edge of a START cycle; leaves on the falling edge
  // just after the DONE exit edge (FETCH or IDLE).
  task automatic handshake(input bit ack_pulse, input bit done_redirect,
                           input logic [7:0] tgt, input bit run_v);
    cyc();
    check("ack_s_low", bus.s, 1'b0);
    if (ack_pulse) begin
      bus.pc_load   = 1'b1;
      bus.pc_target = tgt;
      cyc();
      bus.pc_load   = 1'b0;
    end
    bus.run = run_v;
    bus.w   = 1'b0;
    cyc();
    cyc();
    check("done_no_rd", bus.mem_rd, 1'b0);
    bus.w = 1'b1;
    if (done_redirect) begin
      bus.pc_load   = 1'b1;
      bus.pc_target = tgt;
    end
    cyc();
    bus.pc_load = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'hD105;
    mem[8'h01] = 16'hD202;
    mem[8'h02] = 16'h1234;
    mem[8'h40] = 16'hE000;
    mem[8'hFF] = 16'h2AAA;

    reset         = 1'b0;
    bus.run       = 1'b0;
    bus.w         = 1'b1;
    bus.pc_load   = 1'b0;
    bus.pc_target = 8'h00;
    cyc();
    cyc();
    check("rst_pc", bus.pc, 8'h00);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_load", bus.load_instr, 1'b0);
    check("rst_s", bus.s, 1'b0);
    check("rst_instr", bus.instr_out, 16'h0000);
    check("rst_halted", bus.halted, 1'b0);

    // First step: D105 at address 0.
    reset   = 1'b1;
    bus.run = 1'b1;
    cyc();
    check("f0_rd", bus.mem_rd, 1'b1);
    check("f0_addr", bus.mem_addr, 8'h00);
    cyc();
    check("l0_load", bus.load_instr, 1'b1);
    check("l0_instr", bus.instr_out, 16'hD105);
    check("l0_s", bus.s, 1'b0);
    cyc();
    check("s0_s", bus.s, 1'b1);
    check("s0_load", bus.load_instr, 1'b0);
    check("s0_pc", bus.pc, 8'h01);
    check("s0_instr", bus.instr_out, 16'h0000);
    handshake(1'b0, 1'b0, 8'h00, 1'b1);

    // Second step: D202 at address 1; run dropped and pc_load pulsed in ACK.
    check("f1_rd", bus.mem_rd, 1'b1);
    check("f1_addr", bus.mem_addr, 8'h01);
    cyc();
    check("l1_instr", bus.instr_out, 16'hD202);
    check("l1_load", bus.load_instr, 1'b1);
    cyc();
    check("s1_pc", bus.pc, 8'h02);
    handshake(1'b1, 1'b0, 8'h40, 1'b0);
    check("idle_rd", bus.mem_rd, 1'b0);
    check("ack_redirect_ignored", bus.pc, 8'h02);
    repeat (3) cyc();
    check("idle_still_rd", bus.mem_rd, 1'b0);
    check("idle_still_s", bus.s, 1'b0);

    // Resume from pc=2, then redirect to 0xFF on DONE.
    bus.run = 1'b1;
    cyc();
    check("f2_addr", bus.mem_addr, 8'h02);
    cyc();
    check("l2_instr", bus.instr_out, 16'h1234);
    cyc();
    check("s2_pc", bus.pc, 8'h03);
    handshake(1'b0, 1'b1, 8'hFF, 1'b1);
    check("redir_ff_addr", bus.mem_addr, 8'hFF);
    check("redir_ff_rd", bus.mem_rd, 1'b1);
    cyc();
    check("lff_load", bus.load_instr, 1'b1);
    cyc();
    check("wrap_pc", bus.pc, 8'h00);
    handshake(1'b0, 1'b0, 8'h00, 1'b1);
    check("wrap_addr", bus.mem_addr, 8'h00);
    cyc();
    cyc();
    check("s3_pc", bus.pc, 8'h01);
    handshake(1'b0, 1'b1, 8'h40, 1'b1);
    check("redir_40_addr", bus.mem_addr, 8'h40);
    cyc();
    check("l40_instr", bus.instr_out, 16'hE000);
    check("l40_no_load", bus.load_instr, 1'b0);
    cyc();
    check("h40_halted", bus.halted, 1'b1);
    check("h40_s", bus.s, 1'b0);
    check("h40_pc", bus.pc, 8'h40);

    // HALT as the very first word.
    reset      = 1'b0;
    mem[8'h00] = 16'hE000;
    cyc();
    check("rst_clears_halt", bus.halted, 1'b0);
    reset = 1'b1;
    cyc();
    check("hf_addr", bus.mem_addr, 8'h00);
    cyc();
    check("hl_no_load", bus.load_instr, 1'b0);
    cyc();
    check("hh_halted", bus.halted, 1'b1);
    check("hh_s", bus.s, 1'b0);
    check("hh_pc", bus.pc, 8'h00);
    repeat (4) cyc();
    check("hh_sticky", bus.halted, 1'b1);
    check("hh_no_rd", bus.mem_rd, 1'b0);
    check("hh_pc_hold", bus.pc, 8'h00);

    // Asynchronous reset while s is high.
    reset      = 1'b0;
    mem[8'h00] = 16'hD105;
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    cyc();
    check("pre_rst_s", bus.s, 1'b1);
    check("pre_rst_pc", bus.pc, 8'h01);
    #1 reset = 1'b0;
    #1;
    check("async_s", bus.s, 1'b0);
    check("async_pc", bus.pc, 8'h00);
    check("async_halted", bus.halted, 1'b0);
    check("async_rd", bus.mem_rd, 1'b0);
    #20;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
